// File: rtl/tea_pkg.sv
// Shared TEA definitions: round constant, mode encoding, stage record and
// the per-cycle sum helper used to build elaboration-time constants.
package tea_pkg;

  localparam logic [31:0] DELTA = 32'h9E3779B9;

  typedef enum logic {
    ENC = 1'b0,
    DEC = 1'b1
  } mode_e;

  typedef struct packed {
    logic         valid;
    mode_e        mode;
    logic [127:0] key;
    logic [63:0]  data;
  } stage_t;

  function automatic logic [31:0] cycleSum(input logic [31:0] r);
    return DELTA * r;
  endfunction

endpackage

// File: rtl/tea_cycle.sv
// One full combinational TEA cycle (both half-rounds) in either direction;
// the caller supplies the sum constant that matches the direction.
module tea_cycle
  import tea_pkg::*;
(
  input  mode_e        i_mode,
  input  logic [31:0]  i_sum,
  input  logic [127:0] i_key,
  input  logic [31:0]  i_v0,
  input  logic [31:0]  i_v1,
  output logic [31:0]  o_v0,
  output logic [31:0]  o_v1
);

  logic [31:0] w_k0, w_k1, w_k2, w_k3;
  logic [31:0] w_encV0, w_encV1, w_decV0, w_decV1;

  function automatic logic [31:0] mix(input logic [31:0] v, input logic [31:0] s,
                                      input logic [31:0] ka, input logic [31:0] kb);
    return ((v << 4) + ka) ^ (v + s) ^ ((v >> 5) + kb);
  endfunction

  assign {w_k0, w_k1, w_k2, w_k3} = i_key;

  // Decrypt undoes the half-rounds in reverse order, so v1 is unwound first.
  assign w_encV0 = i_v0 + mix(i_v1, i_sum, w_k0, w_k1);
  assign w_encV1 = i_v1 + mix(w_encV0, i_sum, w_k2, w_k3);
  assign w_decV1 = i_v1 - mix(i_v0, i_sum, w_k2, w_k3);
  assign w_decV0 = i_v0 - mix(w_decV1, i_sum, w_k0, w_k1);

  assign o_v0 = (i_mode == DEC) ? w_decV0 : w_encV0;
  assign o_v1 = (i_mode == DEC) ? w_decV1 : w_encV1;

endmodule

// File: rtl/tea_pipe.sv
// Fully pipelined TEA encrypt/decrypt engine with per-block mode and key;
// the whole pipe advances in lockstep whenever the output slot can move.
module tea_pipe
  import tea_pkg::*;
#(
  parameter int CYCLES           = 32,
  parameter int CYCLES_PER_STAGE = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         in_mode,
  input  logic [63:0]  in_block,
  input  logic [127:0] in_key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [63:0]  out_block,
  output logic         out_mode,
  output logic         busy
);

  localparam int S = CYCLES / CYCLES_PER_STAGE;

  stage_t r_stage [0:S];
  stage_t w_next  [1:S];
  logic   w_advance;

  assign w_advance = !r_stage[S].valid || out_ready;
  assign in_ready  = w_advance;

  // Stage i applies global cycles (i-1)*CPS+1 .. i*CPS to its predecessor.
  for (genvar i = 1; i <= S; i++) begin : g_stage
    logic [31:0] w_v0 [0:CYCLES_PER_STAGE];
    logic [31:0] w_v1 [0:CYCLES_PER_STAGE];

    assign w_v0[0] = r_stage[i-1].data[63:32];
    assign w_v1[0] = r_stage[i-1].data[31:0];

    for (genvar j = 0; j < CYCLES_PER_STAGE; j++) begin : g_cycle
      localparam int          R       = (i - 1) * CYCLES_PER_STAGE + j + 1;
      localparam logic [31:0] SUM_ENC = cycleSum(32'(R));
      localparam logic [31:0] SUM_DEC = cycleSum(32'(CYCLES - R + 1));

      tea_cycle u_cycle (
        .i_mode (r_stage[i-1].mode),
        .i_sum  ((r_stage[i-1].mode == DEC) ? SUM_DEC : SUM_ENC),
        .i_key  (r_stage[i-1].key),
        .i_v0   (w_v0[j]),
        .i_v1   (w_v1[j]),
        .o_v0   (w_v0[j+1]),
        .o_v1   (w_v1[j+1])
      );
    end

    assign w_next[i] = '{valid: r_stage[i-1].valid,
                         mode:  r_stage[i-1].mode,
                         key:   r_stage[i-1].key,
                         data:  {w_v0[CYCLES_PER_STAGE], w_v1[CYCLES_PER_STAGE]}};
  end

  // Bubbles are loaded like blocks, so every stage moves on each advance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k <= S; k++) r_stage[k] <= '0;
    end else if (w_advance) begin
      r_stage[0] <= '{valid: in_valid, mode: mode_e'(in_mode), key: in_key, data: in_block};
      for (int k = 1; k <= S; k++) r_stage[k] <= w_next[k];
    end
  end

  always_comb begin
    busy = 1'b0;
    for (int k = 0; k <= S; k++) busy = busy | r_stage[k].valid;
  end

  assign out_valid = r_stage[S].valid;
  assign out_block = r_stage[S].data;
  assign out_mode  = r_stage[S].mode;

endmodule

// File: tb/tb_tea_pipe.sv
// Scoreboard bench running three pipe configurations in lockstep against a
// loop-form TEA reference model.
module tb_tea_pipe;
  import tea_pkg::*;

  localparam int N = 3;
  localparam int CYC [N] = '{32, 32, 16};
  localparam int CPS [N] = '{1, 4, 2};
  localparam int STG [N] = '{32, 8, 8};

  typedef struct {
    logic [63:0] data;
    logic        mode;
    int          acc;
    logic        lat;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         vld = 1'b0;
  logic         inMode = 1'b0;
  logic [63:0]  inBlock = '0;
  logic [127:0] inKey = '0;
  logic         outReady = 1'b1;
  logic         allReady;
  logic         latMode = 1'b1;
  logic         inValid  [N];
  logic         inReady  [N];
  logic         outValid [N];
  logic [63:0]  outBlock [N];
  logic         outMode  [N];
  logic         busyO    [N];
  logic [127:0] keys [4];
  exp_t         sb [N][$];
  int           edgeCnt = 0;
  int           checkCnt = 0;
  int           passCnt = 0;

  initial forever #5 clk = ~clk;

  always @(posedge clk) edgeCnt <= edgeCnt + 1;

  assign allReady = inReady[0] && inReady[1] && inReady[2];

  for (genvar g = 0; g < N; g++) begin : g_dut
    assign inValid[g] = vld && allReady;
    tea_pipe #(.CYCLES(CYC[g]), .CYCLES_PER_STAGE(CPS[g])) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (inValid[g]),
      .in_ready  (inReady[g]),
      .in_mode   (inMode),
      .in_block  (inBlock),
      .in_key    (inKey),
      .out_valid (outValid[g]),
      .out_ready (outReady),
      .out_block (outBlock[g]),
      .out_mode  (outMode[g]),
      .busy      (busyO[g])
    );
  end

  function automatic logic [63:0] teaModel(input logic mode, input logic [127:0] key,
                                           input logic [63:0] blk, input int cycles);
    logic [31:0] v0, v1, k0, k1, k2, k3, sum;
    {v0, v1} = blk;
    {k0, k1, k2, k3} = key;
    if (!mode) begin
      sum = 32'd0;
      for (int r = 0; r < cycles; r++) begin
        sum = sum + DELTA;
        v0 = v0 + (((v1 << 4) + k0) ^ (v1 + sum) ^ ((v1 >> 5) + k1));
        v1 = v1 + (((v0 << 4) + k2) ^ (v0 + sum) ^ ((v0 >> 5) + k3));
      end
    end else begin
      sum = DELTA * 32'(cycles);
      for (int r = 0; r < cycles; r++) begin
        v1 = v1 - (((v0 << 4) + k2) ^ (v0 + sum) ^ ((v0 >> 5) + k3));
        v0 = v0 - (((v1 << 4) + k0) ^ (v1 + sum) ^ ((v1 >> 5) + k1));
        sum = sum - DELTA;
      end
    end
    return {v0, v1};
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checkCnt++;
    if (obs !== exp) $display("[TB] FAIL %s: got %h, expected %h", tag, obs, exp);
    else passCnt++;
  endtask

  // One clock: drive at the falling edge, sample handshakes shortly after.
  task automatic applyStimulus(input logic v, input logic m, input logic [127:0] k,
                               input logic [63:0] b, input logic ordy,
                               input logic useFixed = 1'b0, input logic [63:0] fixedExp = '0);
    exp_t e;
    @(negedge clk);
    vld = v; inMode = m; inKey = k; inBlock = b; outReady = ordy;
    #2;
    for (int g = 0; g < N; g++) begin
      checkOutput($sformatf("d%0d_in_ready", g), 64'(inReady[g]), 64'(!outValid[g] || outReady));
      if (outValid[g] && outReady) begin
        if (sb[g].size() == 0) begin
          checkOutput($sformatf("d%0d_spurious_out", g), 64'(1), 64'(0));
        end else begin
          e = sb[g].pop_front();
          checkOutput($sformatf("d%0d_out_block", g), outBlock[g], e.data);
          checkOutput($sformatf("d%0d_out_mode", g), 64'(outMode[g]), 64'(e.mode));
          if (e.lat) checkOutput($sformatf("d%0d_latency", g), 64'(edgeCnt - e.acc), 64'(STG[g]));
        end
      end
    end
    if (vld && allReady) begin
      for (int g = 0; g < N; g++) begin
        e.data = (useFixed && CYC[g] == 32) ? fixedExp : teaModel(m, k, b, CYC[g]);
        e.mode = m;
        e.acc  = edgeCnt + 1;
        e.lat  = latMode;
        sb[g].push_back(e);
      end
    end
  endtask

  task automatic drain();
    int left;
    left = 1;
    for (int c = 0; c < 200 && left != 0; c++) begin
      applyStimulus(1'b0, 1'b0, '0, '0, 1'b1);
      left = sb[0].size() + sb[1].size() + sb[2].size();
    end
    checkOutput("drain_empty", 64'(left), 64'(0));
  endtask

  task automatic checkReset(input string tag);
    for (int g = 0; g < N; g++) begin
      checkOutput($sformatf("d%0d_%s_out_valid", g, tag), 64'(outValid[g]), 64'(0));
      checkOutput($sformatf("d%0d_%s_busy", g, tag), 64'(busyO[g]), 64'(0));
      checkOutput($sformatf("d%0d_%s_out_block", g, tag), outBlock[g], 64'(0));
      checkOutput($sformatf("d%0d_%s_out_mode", g, tag), 64'(outMode[g]), 64'(0));
    end
  endtask

  initial begin
    for (int i = 0; i < 4; i++) keys[i] = {$urandom, $urandom, $urandom, $urandom};
    repeat (2) @(negedge clk);
    #2;
    checkReset("rst");
    rst = 1'b0;

    // Known vectors: zero key/block encrypt, then decrypt of that result.
    applyStimulus(1'b1, 1'b0, '0, 64'h0, 1'b1, 1'b1, 64'h41EA3A0A_94BAA940);
    applyStimulus(1'b1, 1'b1, '0, 64'h41EA3A0A_94BAA940, 1'b1, 1'b1, 64'h0);
    drain();

    // Back-to-back stream, alternating direction and rotating keys.
    for (int i = 0; i < 40; i++)
      applyStimulus(1'b1, 1'(i % 2), keys[i % 4], {$urandom, $urandom}, 1'b1);
    drain();

    // Random backpressure and input gaps.
    latMode = 1'b0;
    for (int i = 0; i < 250; i++)
      applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    keys[$urandom_range(0, 3)], {$urandom, $urandom},
                    1'($urandom_range(0, 1)));
    drain();

    // Reset with blocks in flight, then confirm nothing stale emerges.
    latMode = 1'b1;
    for (int i = 0; i < 10; i++)
      applyStimulus(1'b1, 1'(i % 2), keys[i % 4], {$urandom, $urandom}, 1'b1);
    @(negedge clk);
    rst = 1'b1; vld = 1'b0;
    #2;
    checkReset("midrst");
    for (int g = 0; g < N; g++) sb[g].delete();
    @(negedge clk);
    #2;
    checkReset("midrst2");
    rst = 1'b0;
    repeat (40) applyStimulus(1'b0, 1'b0, '0, '0, 1'b1);
    applyStimulus(1'b1, 1'b0, keys[2], 64'h01234567_89ABCDEF, 1'b1);
    drain();

    $display("%0d/%0d checks passed", passCnt, checkCnt);
    $finish;
  end

endmodule

// File: doc/tea_pipe.md
TEA_PIPE -- requirements
Module: tea_pipe

Interface
REQ-001 Parameter CYCLES, default 32, meaning number of TEA cycles per block; legal values are 1..64 and SHALL be a multiple of CYCLES_PER_STAGE.
REQ-002 Parameter CYCLES_PER_STAGE, default 1, meaning TEA cycles computed combinationally per pipeline stage; S = CYCLES/CYCLES_PER_STAGE.
REQ-003 clk  in  1  clock; all registers update on the rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 in_valid  in  1  input block present.
REQ-006 in_ready  out  1  block accepted at the edge where in_valid && in_ready.
REQ-007 in_mode  in  1  0 = encrypt, 1 = decrypt, captured per block.
REQ-008 in_block  in  64  [63:32] = v0, [31:0] = v1.
REQ-009 in_key  in  128  [127:96] = k0 ... [31:0] = k3, captured per block.
REQ-010 out_valid  out  1  result present.
REQ-011 out_ready  in  1  downstream accepts the result at the edge where out_valid && out_ready.
REQ-012 out_block  out  64  result, packed as in_block.
REQ-013 out_mode  out  1  echo of in_mode for this block.
REQ-014 busy  out  1  high when any stage holds a valid block.

Function
REQ-015 Stage 0 is an input register; stages 1..S each hold data after i*CYCLES_PER_STAGE TEA cycles; stage S drives the outputs.
REQ-016 Each stage register carries valid, mode, key and the 64-bit data, so mode and key may differ on every block.
REQ-017 advance = !out_valid || out_ready; in_ready = advance, combinational from out_ready.
REQ-018 On an edge with advance = 1:
- every stage loads its predecessor's processed contents, including valid;
- stage 0 loads {in_valid, in_mode, in_key, in_block}.
REQ-019 On an edge with advance = 0, all stages hold their contents.
REQ-020 Bubbles are not compressed; they travel through the pipeline like blocks.
REQ-021 Latency: a block accepted at edge t is on out_* after edge t+S when advance stays 1 throughout; each stall cycle adds one cycle.
REQ-022 Throughput: one block per clock while out_ready = 1.
REQ-023 Encrypt, global cycle r (1..CYCLES), all arithmetic mod 2^32:
- sum = DELTA*r;
- v0 += ((v1<<4)+k0) ^ (v1+sum) ^ ((v1>>5)+k1);
- then v1 += ((v0<<4)+k2) ^ (v0+sum) ^ ((v0>>5)+k3).
REQ-024 Decrypt, global cycle r, mod 2^32:
- sum = DELTA*(CYCLES-r+1);
- v1 -= ((v0<<4)+k2) ^ (v0+sum) ^ ((v0>>5)+k3);
- then v0 -= ((v1<<4)+k0) ^ (v1+sum) ^ ((v1>>5)+k1).
REQ-025 DELTA = 32'h9E3779B9; all per-cycle sum constants SHALL be elaboration-time constants (no runtime sum register).
REQ-026 Shifts are logical; >>5 fills with zeros.
REQ-027 out_block, out_mode and out_valid SHALL be driven directly from stage S registers (no combinational path from in_*).
REQ-028 The result for a block is independent of stalls, bubbles and neighbouring blocks' mode or key.

Reset
REQ-029 While rst is high:
- every stage valid, data, mode and key register SHALL be 0;
- out_valid = 0, out_block = 0, out_mode = 0, busy = 0.
REQ-030 Reset asserted mid-operation discards all in-flight blocks immediately; no partial result is ever presented.
REQ-031 After rst deasserts, in_ready = 1 on the first cycle, since out_valid = 0.

Structure
REQ-032 The shared package tea_pkg SHALL hold DELTA, the mode encoding (ENC = 0, DEC = 1) and a stage struct {valid, mode, key[127:0], data[63:0]}.
REQ-033 A sub-module tea_cycle SHALL be combinational: one full TEA cycle, inputs mode/sum/key/v0/v1, outputs v0/v1.
REQ-034 Each stage instantiates CYCLES_PER_STAGE tea_cycle instances in a generate loop.

Verification
REQ-035 Key 0, block 0, encrypt, CYCLES = 32 -> out_block = 41EA3A0A_94BAA940 after 33 edges.
REQ-036 Key 0, block 41EA3A0A_94BAA940, decrypt -> out_block = 0, out_mode = 1.
REQ-037 Stream alternating encrypt/decrypt blocks with 4 random keys back-to-back, out_ready = 1:
- one result per clock;
- each result matches the C reference model;
- order is preserved.
REQ-038 Random out_ready (50 %) and random in_valid gaps:
- no block is lost or duplicated;
- in_ready == (!out_valid || out_ready) every cycle.
REQ-039 Pulse rst for one cycle with 10 blocks in flight -> out_valid and busy are 0 during reset; no stale result appears afterwards; the next accepted block is correct.
REQ-040 Repeat REQ-035..037 with (CYCLES, CYCLES_PER_STAGE) = (32, 4) and (16, 2) -> latency = S+1 edges; results match the model.
